imm_gen_pipe: RTL

- Registered, handshaked immediate generator for the decode stage; parametrised successor to the combinational sign-extender.
- Takes a 32-bit instruction, an `ImmSrc` format select and a sideband tag, and returns the XLEN-wide immediate one cycle later.
- Output passes through a 2-entry skid buffer, so both sides use valid/ready without combinational ready paths.
- Invalid format selects raise an error flag and bump a saturating counter; silicon-visible reporting replaces simulation-only checking.

---
 rtl/imm_pkg.sv | 26 ++
 rtl/imm_format.sv | 40 ++++
 rtl/imm_gen_pipe.sv | 132 +++++++++++++
 3 files changed

// File: rtl/imm_pkg.sv
// Shared types for the registered immediate generator: format selects,
// skid-buffer occupancy states and the XLEN legality check.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I     = 3'b000,
    IMM_S     = 3'b001,
    IMM_B     = 3'b010,
    IMM_U     = 3'b011,
    IMM_J     = 3'b100,
    IMM_SHAMT = 3'b101,
    IMM_CSR   = 3'b110,
    IMM_BAD   = 3'b111
  } imm_src_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_t;

  function automatic bit imm_xlen_legal(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_format.sv
// Combinational immediate extraction for all RISC-V formats, widened to XLEN.
module imm_format
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_src,
  output logic [XLEN-1:0] imm,
  output logic            err
);

  // Every format fits a signed 32-bit value whose sign-extension to XLEN is
  // correct (shamt and CSR uimm have bit 31 clear, so they zero-extend).
  logic signed [31:0] imm32;

  always_comb begin
    imm32 = '0;
    err   = 1'b0;
    case (imm_src_t'(imm_src))
      IMM_I:     imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:     imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:     imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                          instr[11:8], 1'b0};
      IMM_U:     imm32 = {instr[31:12], 12'b0};
      IMM_J:     imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                          instr[30:21], 1'b0};
      IMM_SHAMT: imm32 = (XLEN == 64) ? {26'b0, instr[25:20]}
                                      : {27'b0, instr[24:20]};
      IMM_CSR:   imm32 = {27'b0, instr[19:15]};
      default: begin
        imm32 = '0;
        err   = 1'b1;
      end
    endcase
  end

  assign imm = XLEN'(imm32);

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: format decode at the input, then a 2-entry
// skid buffer (output register + skid register) and a saturating error counter.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int TAG_W     = 32,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instr,
  input  logic [2:0]           ImmSrc,
  input  logic [TAG_W-1:0]     tag_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      ImmOp,
  output logic [TAG_W-1:0]     tag_out,
  output logic                 imm_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  if (!imm_xlen_legal(XLEN)) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  buf_state_t             state_q, state_d;
  logic [XLEN-1:0]        out_imm_q, out_imm_d, skid_imm_q, skid_imm_d;
  logic [TAG_W-1:0]       out_tag_q, out_tag_d, skid_tag_q, skid_tag_d;
  logic                   out_err_q, out_err_d, skid_err_q, skid_err_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic [XLEN-1:0]        new_imm;
  logic                   new_err;
  logic                   accept, deliver;

  imm_format #(.XLEN(XLEN)) u_format (
    .instr   (instr),
    .imm_src (ImmSrc),
    .imm     (new_imm),
    .err     (new_err)
  );

  // Both handshake outputs come straight from the state register.
  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && out_ready;

  always_comb begin
    state_d    = state_q;
    out_imm_d  = out_imm_q;
    out_tag_d  = out_tag_q;
    out_err_d  = out_err_q;
    skid_imm_d = skid_imm_q;
    skid_tag_d = skid_tag_q;
    skid_err_d = skid_err_q;
    err_cnt_d  = err_cnt_q;

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d   = ST_ONE;
          out_imm_d = new_imm;
          out_tag_d = tag_in;
          out_err_d = new_err;
        end
      end
      ST_ONE: begin
        if (accept && deliver) begin
          out_imm_d = new_imm;
          out_tag_d = tag_in;
          out_err_d = new_err;
        end else if (accept) begin
          state_d    = ST_TWO;
          skid_imm_d = new_imm;
          skid_tag_d = tag_in;
          skid_err_d = new_err;
        end else if (deliver) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (deliver) begin
          state_d   = ST_ONE;
          out_imm_d = skid_imm_q;
          out_tag_d = skid_tag_q;
          out_err_d = skid_err_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // Flush wins over any same-edge accept or deliver; the counter survives it.
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (accept && new_err && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      out_imm_q  <= '0;
      out_tag_q  <= '0;
      out_err_q  <= 1'b0;
      skid_imm_q <= '0;
      skid_tag_q <= '0;
      skid_err_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      out_imm_q  <= out_imm_d;
      out_tag_q  <= out_tag_d;
      out_err_q  <= out_err_d;
      skid_imm_q <= skid_imm_d;
      skid_tag_q <= skid_tag_d;
      skid_err_q <= skid_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign ImmOp     = out_imm_q;
  assign tag_out   = out_tag_q;
  assign imm_err   = out_err_q;
  assign err_count = err_cnt_q;

endmodule
